// File: rtl/rstation_pkg.sv
// Shared definitions for the reservation station: micro-op layout and
// register-address constants used by the queue and the issue stage.
package rstation_pkg;

    localparam int OPW = 4;
    localparam logic [2:0] PC_ADDR = 3'b011;

    typedef struct packed {
        logic [2:0]     a_addr;
        logic [2:0]     b_addr;
        logic [15:0]    pc;
        logic [1:0]     dest_addr;
        logic           dest_wr;
        logic           w_flags;
        logic [OPW-1:0] alu_op;
    } uop_t;

endpackage

// File: rtl/uop_fifo.sv
// Circular micro-op queue with occupancy count; flush empties it in one cycle.
// Storage is deliberately left unreset; only pointers and count are control.
module uop_fifo #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  rstation_pkg::uop_t       wr_data,
    output rstation_pkg::uop_t       head,
    output logic [$clog2(DEPTH):0]   count
);
    import rstation_pkg::*;

    localparam int AW = $clog2(DEPTH);

    uop_t          mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // No fall-through: a push into an empty queue shows at the head next cycle.
    assign head = mem[rd_ptr];

endmodule

// File: rtl/rstation.sv
// In-order reservation station: queues decoded micro-ops, drives register
// file read addresses from the head, and registers write controls for EX.
module rstation #(
    parameter int DEPTH = 4,
    parameter int OPW   = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           id_valid,
    output logic           id_ready,
    input  logic [2:0]     id_a_addr,
    input  logic [2:0]     id_b_addr,
    input  logic [15:0]    id_pc,
    input  logic [1:0]     id_dest_addr,
    input  logic           id_dest_wr,
    input  logic           id_w_flags,
    input  logic [OPW-1:0] id_alu_op,
    input  logic           flush,
    input  logic           rmw_busy,
    output logic [2:0]     r_a_addr,
    output logic [2:0]     r_b_addr,
    output logic [15:0]    r_pc,
    output logic           ex_valid,
    output logic [OPW-1:0] ex_alu_op,
    output logic           dest_r_wr,
    output logic [1:0]     dest_r_addr,
    output logic           dest_w_flags
);
    import rstation_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    uop_t          in_uop_p0;
    uop_t          head_p0;
    logic [CW-1:0] count;
    logic          push;
    logic          issue_p0;

    logic           vld_p1;
    logic [OPW-1:0] alu_op_p1;
    logic [1:0]     dest_addr_p1;
    logic           dest_wr_p1;
    logic           w_flags_p1;

    assign in_uop_p0 = '{a_addr:    id_a_addr,
                         b_addr:    id_b_addr,
                         pc:        id_pc,
                         dest_addr: id_dest_addr,
                         dest_wr:   id_dest_wr,
                         w_flags:   id_w_flags,
                         alu_op:    id_alu_op};

    // Ready ignores a same-cycle pop so it never forms a combinational path to issue.
    assign id_ready = (count != CW'(DEPTH)) && !flush;
    assign push     = id_valid && id_ready;
    assign issue_p0 = (count != '0) && !rmw_busy && !flush;

    uop_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (issue_p0),
        .flush   (flush),
        .wr_data (in_uop_p0),
        .head    (head_p0),
        .count   (count)
    );

    assign r_a_addr = head_p0.a_addr;
    assign r_b_addr = head_p0.b_addr;
    assign r_pc     = head_p0.pc;

    // p0 -> p1: issue stage to EX stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1       <= 1'b0;
            alu_op_p1    <= '0;
            dest_addr_p1 <= '0;
            dest_wr_p1   <= 1'b0;
            w_flags_p1   <= 1'b0;
        end else if (issue_p0) begin
            vld_p1       <= 1'b1;
            alu_op_p1    <= head_p0.alu_op;
            dest_addr_p1 <= head_p0.dest_addr;
            dest_wr_p1   <= head_p0.dest_wr;
            w_flags_p1   <= head_p0.w_flags;
        end else begin
            vld_p1 <= 1'b0;
        end
    end

    assign ex_valid     = vld_p1;
    assign ex_alu_op    = alu_op_p1;
    assign dest_r_wr    = vld_p1 && dest_wr_p1;
    assign dest_w_flags = vld_p1 && w_flags_p1;
    assign dest_r_addr  = dest_addr_p1;

endmodule

// File: tb/tb_rstation.sv
// Directed bench for rstation: queue-level reference model checked every
// cycle, plus literal expectations for the key scenarios.
module tb_rstation;

    localparam int DEPTH = 4;
    localparam int OPW   = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           id_valid;
    logic           id_ready;
    logic [2:0]     id_a_addr;
    logic [2:0]     id_b_addr;
    logic [15:0]    id_pc;
    logic [1:0]     id_dest_addr;
    logic           id_dest_wr;
    logic           id_w_flags;
    logic [OPW-1:0] id_alu_op;
    logic           flush;
    logic           rmw_busy;
    logic [2:0]     r_a_addr;
    logic [2:0]     r_b_addr;
    logic [15:0]    r_pc;
    logic           ex_valid;
    logic [OPW-1:0] ex_alu_op;
    logic           dest_r_wr;
    logic [1:0]     dest_r_addr;
    logic           dest_w_flags;

    always #5 clk = ~clk;

    rstation #(.DEPTH(DEPTH), .OPW(OPW)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .id_valid     (id_valid),
        .id_ready     (id_ready),
        .id_a_addr    (id_a_addr),
        .id_b_addr    (id_b_addr),
        .id_pc        (id_pc),
        .id_dest_addr (id_dest_addr),
        .id_dest_wr   (id_dest_wr),
        .id_w_flags   (id_w_flags),
        .id_alu_op    (id_alu_op),
        .flush        (flush),
        .rmw_busy     (rmw_busy),
        .r_a_addr     (r_a_addr),
        .r_b_addr     (r_b_addr),
        .r_pc         (r_pc),
        .ex_valid     (ex_valid),
        .ex_alu_op    (ex_alu_op),
        .dest_r_wr    (dest_r_wr),
        .dest_r_addr  (dest_r_addr),
        .dest_w_flags (dest_w_flags)
    );

    typedef struct {
        logic [2:0]  a;
        logic [2:0]  b;
        logic [15:0] pc;
        logic [1:0]  d;
        logic        dwr;
        logic        wf;
        logic [3:0]  op;
    } op_t;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: queue of pending ops and the op sitting in EX.
    op_t  q[$];
    op_t  m_ex;
    bit   m_v;
    bit   do_push;
    bit   do_iss;
    op_t  in_op;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_v  = 1'b0;
            m_ex = '{a: 0, b: 0, pc: 0, d: 0, dwr: 0, wf: 0, op: 0};
        end else begin
            do_push = id_valid && (q.size() < DEPTH) && !flush;
            do_iss  = (q.size() != 0) && !rmw_busy && !flush;
            in_op   = '{a: id_a_addr, b: id_b_addr, pc: id_pc, d: id_dest_addr,
                        dwr: id_dest_wr, wf: id_w_flags, op: id_alu_op};
            if (flush) begin
                q.delete();
                m_v = 1'b0;
            end else begin
                if (do_iss) begin
                    m_ex = q.pop_front();
                    m_v  = 1'b1;
                end else begin
                    m_v = 1'b0;
                end
                if (do_push) q.push_back(in_op);
            end
        end
    end

    always @(negedge clk) begin
        chk("id_ready", {31'b0, id_ready}, {31'b0, (q.size() != DEPTH) && !flush});
        chk("ex_valid", {31'b0, ex_valid}, {31'b0, m_v});
        chk("dest_r_wr", {31'b0, dest_r_wr}, {31'b0, m_v && m_ex.dwr});
        chk("dest_w_flags", {31'b0, dest_w_flags}, {31'b0, m_v && m_ex.wf});
        if (m_v) begin
            chk("dest_r_addr", {30'b0, dest_r_addr}, {30'b0, m_ex.d});
            chk("ex_alu_op", {28'b0, ex_alu_op}, {28'b0, m_ex.op});
        end
        if (q.size() != 0) begin
            chk("r_a_addr", {29'b0, r_a_addr}, {29'b0, q[0].a});
            chk("r_b_addr", {29'b0, r_b_addr}, {29'b0, q[0].b});
            chk("r_pc", {16'b0, r_pc}, {16'b0, q[0].pc});
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [2:0] a, input logic [2:0] b, input logic [15:0] pc,
                          input logic [1:0] d, input logic dwr, input logic wf,
                          input logic [3:0] op);
        id_valid     = 1'b1;
        id_a_addr    = a;
        id_b_addr    = b;
        id_pc        = pc;
        id_dest_addr = d;
        id_dest_wr   = dwr;
        id_w_flags   = wf;
        id_alu_op    = op;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 100000");
        $fatal(1);
    end

    initial begin
        bit acc;
        rst_n = 1'b0;
        flush = 1'b0;
        rmw_busy = 1'b0;
        set_op(0, 0, 0, 0, 0, 0, 0);
        id_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ex_valid", {31'b0, ex_valid}, 32'd0);
        chk("rst_dest_r_wr", {31'b0, dest_r_wr}, 32'd0);
        chk("rst_id_ready", {31'b0, id_ready}, 32'd1);
        chk("rst_dest_r_addr", {30'b0, dest_r_addr}, 32'd0);
        chk("rst_ex_alu_op", {28'b0, ex_alu_op}, 32'd0);
        tick();

        // Single op latency
        set_op(3'd1, 3'd2, 16'h0100, 2'd0, 1'b1, 1'b0, 4'd5);
        tick();
        id_valid = 1'b0;
        @(negedge clk);
        chk("lat_r_a", {29'b0, r_a_addr}, 32'd1);
        chk("lat_r_b", {29'b0, r_b_addr}, 32'd2);
        chk("lat_r_pc", {16'b0, r_pc}, 32'h0100);
        chk("lat_wr_early", {31'b0, dest_r_wr}, 32'd0);
        tick();
        @(negedge clk);
        chk("lat_wr", {31'b0, dest_r_wr}, 32'd1);
        chk("lat_waddr", {30'b0, dest_r_addr}, 32'd0);
        chk("lat_op", {28'b0, ex_alu_op}, 32'd5);
        tick();
        @(negedge clk);
        chk("lat_wr_once", {31'b0, dest_r_wr}, 32'd0);
        tick();

        // Fill while stalled, then drain in order
        rmw_busy = 1'b1;
        for (int i = 0; i < 5; i++) begin
            set_op(3'(i), 3'(i + 1), 16'(16'h0200 + i), 2'(i), 1'b1, 1'b0, 4'(i));
            @(negedge clk);
            if (i == 4) chk("full_ready", {31'b0, id_ready}, 32'd0);
            tick();
        end
        rmw_busy = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (k == 0) chk("full_ready_issue", {31'b0, id_ready}, 32'd0);
            if (k == 1) chk("ready_rise", {31'b0, id_ready}, 32'd1);
            if (k >= 1) begin
                chk("drain_wr", {31'b0, dest_r_wr}, 32'd1);
                chk("drain_op", {28'b0, ex_alu_op}, 32'(k - 1));
            end
            acc = id_valid && id_ready;
            tick();
            if (acc) id_valid = 1'b0;
        end
        id_valid = 1'b0;
        tick();
        tick();

        // Back-to-back dependence
        set_op(3'd0, 3'd0, 16'h0300, 2'd2, 1'b1, 1'b0, 4'd1);
        tick();
        set_op(3'd2, 3'd5, 16'h0301, 2'd1, 1'b1, 1'b0, 4'd2);
        tick();
        id_valid = 1'b0;
        @(negedge clk);
        chk("dep_r_a", {29'b0, r_a_addr}, 32'd2);
        chk("dep_wr", {31'b0, dest_r_wr}, 32'd1);
        chk("dep_waddr", {30'b0, dest_r_addr}, 32'd2);
        tick();
        @(negedge clk);
        chk("dep_nobubble", {31'b0, ex_valid}, 32'd1);
        chk("dep_cons_op", {28'b0, ex_alu_op}, 32'd2);
        chk("dep_cons_addr", {30'b0, dest_r_addr}, 32'd1);
        tick();

        // Flush with ops queued and EX live
        rmw_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            set_op(3'd1, 3'd1, 16'h0400, 2'(i), 1'b1, 1'b0, 4'(8 + i));
            tick();
        end
        id_valid = 1'b0;
        rmw_busy = 1'b0;
        tick();
        flush = 1'b1;
        rmw_busy = 1'b1;
        @(negedge clk);
        chk("flush_ex_wr", {31'b0, dest_r_wr}, 32'd1);
        chk("flush_ex_addr", {30'b0, dest_r_addr}, 32'd0);
        chk("flush_ready", {31'b0, id_ready}, 32'd0);
        tick();
        flush = 1'b0;
        rmw_busy = 1'b0;
        @(negedge clk);
        chk("post_flush_valid", {31'b0, ex_valid}, 32'd0);
        chk("post_flush_ready", {31'b0, id_ready}, 32'd1);
        tick();
        tick();
        @(negedge clk);
        chk("post_flush_quiet", {31'b0, dest_r_wr}, 32'd0);
        tick();

        // PC operand and flags-only op
        set_op(3'b011, 3'd1, 16'hBEEF, 2'd1, 1'b0, 1'b1, 4'd9);
        tick();
        id_valid = 1'b0;
        @(negedge clk);
        chk("pc_r_a", {29'b0, r_a_addr}, 32'd3);
        chk("pc_r_pc", {16'b0, r_pc}, 32'hBEEF);
        tick();
        @(negedge clk);
        chk("flags_wf", {31'b0, dest_w_flags}, 32'd1);
        chk("flags_nowr", {31'b0, dest_r_wr}, 32'd0);
        tick();

        // Async reset mid-stream
        rmw_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_op(3'd2, 3'd0, 16'h0500, 2'(i + 1), 1'b1, 1'b0, 4'(12 + i));
            tick();
        end
        id_valid = 1'b0;
        rmw_busy = 1'b0;
        tick();
        rmw_busy = 1'b1;
        chk("pre_rst_wr", {31'b0, dest_r_wr}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_wr", {31'b0, dest_r_wr}, 32'd0);
        chk("arst_valid", {31'b0, ex_valid}, 32'd0);
        tick();
        rst_n = 1'b1;
        rmw_busy = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk("no_stale_issue", {31'b0, ex_valid}, 32'd0);
        chk("post_rst_ready", {31'b0, id_ready}, 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
